spike_handshake_rx: RTL and testbench



---
 rtl/spike_handshake_rx.sv | 105 ++++++++++
 tb/tb_spike_handshake_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_handshake_rx.sv
// spike_handshake_rx: SNN-side receiver for the CNN->SNN spike link.
// Completes the 4-phase req/ack handshake against an already-synchronized
// request, buffers {time, addr} in a first-word-fall-through FIFO and presents
// the events as a ready/valid stream to the SNN core.
// Ports:
//   clk, rst_n                    SNN clock, asynchronous active-low reset
//   i_req / o_ack                 synchronized spike valid / registered ack
//   i_spike_time, i_spike_addr    spike payload, stable while the sender's valid is high
//   i_last_sent                   synchronized CNN done level
//   i_clear                       one-cycle pulse starting a new inference
//   o_evt_valid, i_evt_ready      event stream handshake
//   o_evt_time, o_evt_addr        head event (signed time, address)
//   o_stream_done                 sticky: last pixel seen and every event consumed
//   o_evt_count                   saturating count of accepted events
//   o_proto_err                   sticky: request arrived after done
module spike_handshake_rx #(
    parameter int TIME_W     = 32,
    parameter int ADDR_W     = 9,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    output logic              o_ack,
    input  logic [TIME_W-1:0] i_spike_time,
    input  logic [ADDR_W-1:0] i_spike_addr,
    input  logic              i_last_sent,
    input  logic              i_clear,
    output logic              o_evt_valid,
    input  logic              i_evt_ready,
    output logic [TIME_W-1:0] o_evt_time,
    output logic [ADDR_W-1:0] o_evt_addr,
    output logic              o_stream_done,
    output logic [CNT_W-1:0]  o_evt_count,
    output logic              o_proto_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam int DW = TIME_W + ADDR_W;

    typedef enum logic {IDLE, ACK_HIGH} state_t;

    state_t        state;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] occ;
    logic [DW-1:0] last_head;
    logic [DW-1:0] head;
    logic          push, pop;

    // Fullness uses the registered occupancy, so a same-edge pop never frees room.
    // A clear suppresses the capture; the request is still high next cycle and is taken then.
    assign push        = state == IDLE && i_req && occ != OW'(FIFO_DEPTH) && !i_clear;
    assign pop         = o_evt_valid && i_evt_ready;
    assign o_evt_valid = occ != '0;
    // While empty the outputs hold whatever was last presented.
    assign head        = o_evt_valid ? mem[rd_ptr] : last_head;
    assign {o_evt_time, o_evt_addr} = head;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {i_spike_time, i_spike_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            o_ack         <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            last_head     <= '0;
            o_evt_count   <= '0;
            o_stream_done <= 1'b0;
            o_proto_err   <= 1'b0;
        end else begin
            last_head <= head;
            if (i_clear) begin
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                occ           <= '0;
                o_evt_count   <= '0;
                o_stream_done <= 1'b0;
                o_proto_err   <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                occ <= occ + OW'(push) - OW'(pop);
                if (push && o_evt_count != '1) o_evt_count <= o_evt_count + 1'b1;
                // !i_req already implies no push this cycle.
                if (i_last_sent && state == IDLE && !i_req && occ == '0) o_stream_done <= 1'b1;
                if (i_req && o_stream_done) o_proto_err <= 1'b1;
            end
            // The handshake is never broken by a clear: ack follows the request only.
            if (state == IDLE) begin
                if (push) begin
                    state <= ACK_HIGH;
                    o_ack <= 1'b1;
                end
            end else if (!i_req) begin
                state <= IDLE;
                o_ack <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spike_handshake_rx.sv
// tb_spike_handshake_rx: scoreboard bench for spike_handshake_rx.
module tb_spike_handshake_rx;
    typedef logic [40:0] ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic        o_ack;
    logic [31:0] i_spike_time = '0;
    logic [8:0]  i_spike_addr = '0;
    logic        i_last_sent = 1'b0;
    logic        i_clear = 1'b0;
    logic        o_evt_valid;
    logic        i_evt_ready = 1'b0;
    logic [31:0] o_evt_time;
    logic [8:0]  o_evt_addr;
    logic        o_stream_done;
    logic [15:0] o_evt_count;
    logic        o_proto_err;

    int  vecs = 0;
    int  errs = 0;
    ev_t sb[$];

    always #5 clk = ~clk;

    spike_handshake_rx dut (
        .clk(clk), .rst_n(rst_n), .i_req(i_req), .o_ack(o_ack),
        .i_spike_time(i_spike_time), .i_spike_addr(i_spike_addr),
        .i_last_sent(i_last_sent), .i_clear(i_clear),
        .o_evt_valid(o_evt_valid), .i_evt_ready(i_evt_ready),
        .o_evt_time(o_evt_time), .o_evt_addr(o_evt_addr),
        .o_stream_done(o_stream_done), .o_evt_count(o_evt_count),
        .o_proto_err(o_proto_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next posedge whenever valid & ready are seen here.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && o_evt_valid && i_evt_ready && !i_clear) begin
            if (sb.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL evt_unexpected: got %0h expected none", {o_evt_time, o_evt_addr});
            end else begin
                e = sb.pop_front();
                chk("evt_data", {o_evt_time, o_evt_addr}, 64'(e));
            end
        end
    end

    task automatic req_on(input logic [31:0] t, input logic [8:0] a);
        @(posedge clk); #1;
        i_spike_time = t;
        i_spike_addr = a;
        i_req = 1'b1;
        sb.push_back({t, a});
    endtask

    task automatic wait_ack(input logic lvl);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (o_ack == lvl) return;
        end
        chk("ack_timeout", 64'(o_ack), 64'(lvl));
    endtask

    task automatic req_off;
        @(posedge clk); #1;
        i_req = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic send(input logic [31:0] t, input logic [8:0] a);
        req_on(t, a);
        wait_ack(1'b1);
        req_off();
    endtask

    task automatic drain;
        @(posedge clk); #1;
        i_evt_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!o_evt_valid) break;
        end
        chk("drain_left", 64'(sb.size()), 64'(0));
    endtask

    task automatic clear_pulse;
        @(posedge clk); #1;
        i_clear = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        i_clear = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 64'(o_ack), 0);
        chk("rst_valid", 64'(o_evt_valid), 0);
        chk("rst_data", 64'({o_evt_time, o_evt_addr}), 0);
        chk("rst_count", 64'(o_evt_count), 0);
        chk("rst_flags", 64'({o_stream_done, o_proto_err}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single spike: ack exactly one edge after req rises.
        i_evt_ready = 1'b1;
        req_on(32'h0000_0123, 9'h05);
        @(negedge clk);
        chk("single_ack_pre", 64'(o_ack), 0);
        @(negedge clk);
        chk("single_ack", 64'(o_ack), 1);
        req_off();
        drain();
        chk("single_count", 64'(o_evt_count), 1);

        // Back-pressure: four fill the FIFO, the fifth waits for space.
        @(posedge clk); #1;
        i_evt_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(32'h100 + 32'(i), 9'(i));
        req_on(32'h105, 9'd5);
        repeat (4) begin
            @(negedge clk);
            chk("bp_ack_low", 64'(o_ack), 0);
        end
        @(posedge clk); #1;
        i_evt_ready = 1'b1;
        wait_ack(1'b1);
        req_off();
        drain();
        chk("bp_count", 64'(o_evt_count), 6);

        // Push and pop on the same edge at occupancy 2.
        @(posedge clk); #1;
        i_evt_ready = 1'b0;
        send(32'hA, 9'h0A);
        send(32'hB, 9'h0B);
        @(posedge clk); #1;
        i_spike_time = 32'hC;
        i_spike_addr = 9'h0C;
        i_req = 1'b1;
        sb.push_back({32'hC, 9'h0C});
        i_evt_ready = 1'b1;
        @(posedge clk); #1;
        i_evt_ready = 1'b0;
        @(negedge clk);
        chk("pp_ack", 64'(o_ack), 1);
        chk("pp_valid", 64'(o_evt_valid), 1);
        req_off();
        drain();

        // Stream across several pointer wraps with alternating consumer readiness.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            i_evt_ready = i[0];
            send(32'h1000 + 32'(i * 7), 9'(i + 16));
        end
        drain();

        // Done waits for the last pop; a later request flags a protocol error.
        clear_pulse();
        @(posedge clk); #1;
        i_evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h2000 + 32'(i), 9'(i + 40));
        @(posedge clk); #1;
        i_last_sent = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("done_early", 64'(o_stream_done), 0);
        end
        @(posedge clk); #1;
        i_evt_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!o_evt_valid) break;
        end
        chk("done_at_empty", 64'(o_stream_done), 0);
        @(negedge clk);
        chk("done_set", 64'(o_stream_done), 1);
        chk("done_count", 64'(o_evt_count), 3);
        chk("err_before", 64'(o_proto_err), 0);
        send(32'h2FFF, 9'h1FF);
        chk("proto_err", 64'(o_proto_err), 1);
        chk("done_sticky", 64'(o_stream_done), 1);
        drain();
        @(posedge clk); #1;
        i_last_sent = 1'b0;

        // Clear in ACK_HIGH with two events buffered.
        @(posedge clk); #1;
        i_evt_ready = 1'b0;
        send(32'h3001, 9'h31);
        req_on(32'h3002, 9'h32);
        wait_ack(1'b1);
        clear_pulse();
        @(negedge clk);
        chk("clr_valid", 64'(o_evt_valid), 0);
        chk("clr_count", 64'(o_evt_count), 0);
        chk("clr_flags", 64'({o_stream_done, o_proto_err}), 0);
        repeat (2) begin
            chk("clr_ack_held", 64'(o_ack), 1);
            @(negedge clk);
        end
        req_off();
        chk("clr_valid_after", 64'(o_evt_valid), 0);

        // Asynchronous reset mid-handshake, away from any clock edge.
        send(32'h4001, 9'h41);
        req_on(32'h4002, 9'h42);
        wait_ack(1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("areset_ack", 64'(o_ack), 0);
        chk("areset_valid", 64'(o_evt_valid), 0);
        chk("areset_data", 64'({o_evt_time, o_evt_addr}), 0);
        chk("areset_count", 64'(o_evt_count), 0);
        chk("areset_flags", 64'({o_stream_done, o_proto_err}), 0);
        i_req = 1'b0;
        sb.delete();
        #10;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
